pq_cmd_issuer: RTL

//  Initiator front-end for the BRAM/register priority-queue trees. Accepts

---
 rtl/pq_cmd_issuer_if.sv | 33 +++
 rtl/pq_cmd_issuer.sv | 111 +++++++++++
 2 files changed

// File: rtl/pq_cmd_issuer_if.sv
// pq_cmd_issuer_if
//  Command/response handshake bundle between a command source and pq_cmd_issuer.
//  Parameter: DATA_WIDTH - key width.
//  Signals:
//    i_cmd_valid / o_cmd_ready   command handshake
//    i_cmd_op [1:0]              0=ENQ 1=DEQ 2=REPLACE 3=reserved
//    i_cmd_data [DATA_WIDTH]     key for ENQ/REPLACE
//    o_rsp_valid / i_rsp_ready   response handshake
//    o_rsp_data [DATA_WIDTH]     popped root (DEQ/REPLACE), else 0
//    o_rsp_err                   command rejected, tree untouched
//  Modports: master (command source), slave (pq_cmd_issuer).
interface pq_cmd_issuer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [1:0]            i_cmd_op;
  logic [DATA_WIDTH-1:0] i_cmd_data;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_err;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/pq_cmd_issuer.sv
// pq_cmd_issuer
//  Initiator front-end for the priority-queue trees. Accepts ENQ/DEQ/REPLACE
//  commands, issues a one-cycle o_q_wrt/o_q_read pulse to the tree, waits
//  SETTLE_CYCLES idle cycles, then returns one response per accepted command.
//  Ports:
//    CLK, RSTn (synchronous, active-low)
//    cmd_if      pq_cmd_issuer_if.slave: command and response handshakes
//    o_q_wrt, o_q_read, o_q_data          drive the tree's i_wrt/i_read/i_data
//    i_q_full, i_q_empty, i_q_data        tree status and current root
//    o_count                              shadow occupancy, saturating
//  Optional feature macro: PQ_ISSUER_SYNC_CHECK_EN - also reject a command when
//  the tree's full/empty flags disagree with the shadow occupancy.
module pq_cmd_issuer #(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 7,
  parameter int SETTLE_CYCLES = 24
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  pq_cmd_issuer_if.slave                  cmd_if,
  output logic                            o_q_wrt,
  output logic                            o_q_read,
  output logic [DATA_WIDTH-1:0]           o_q_data,
  input  logic                            i_q_full,
  input  logic                            i_q_empty,
  input  logic [DATA_WIDTH-1:0]           i_q_data,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count
);
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] COUNT_MAX   = CNT_W'(QUEUE_SIZE);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {OP_ENQ = 2'd0, OP_DEQ = 2'd1, OP_REP = 2'd2, OP_RSV = 2'd3} op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_in;
  logic [DATA_WIDTH-1:0] key_q;
  logic [SET_W-1:0]      settle_cnt;
  logic                  accept;
  logic                  reject;

  assign op_in              = op_e'(cmd_if.i_cmd_op);
  assign cmd_if.o_cmd_ready = (state_q == IDLE);
  assign accept             = cmd_if.i_cmd_valid && (state_q == IDLE);

  always_comb begin
    reject = 1'b0;
    unique case (op_in)
      OP_ENQ:         reject = i_q_full;
      OP_DEQ, OP_REP: reject = i_q_empty;
      default:        reject = 1'b1;
    endcase
`ifdef PQ_ISSUER_SYNC_CHECK_EN
    if ((i_q_full != (o_count == COUNT_MAX)) || (i_q_empty != (o_count == '0)))
      reject = 1'b1;
`endif
  end

  // o_rsp_valid is registered, so RESP is entered one cycle before it is seen;
  // this gives the k+1 (reject) and k+2+SETTLE_CYCLES (issued) response edges.
  always_comb begin
    state_d  = state_q;
    o_q_wrt  = 1'b0;
    o_q_read = 1'b0;
    o_q_data = '0;
    unique case (state_q)
      IDLE: if (accept) state_d = reject ? RESP : ISSUE;
      ISSUE: begin
        o_q_wrt  = (op_q == OP_ENQ) || (op_q == OP_REP);
        o_q_read = (op_q == OP_DEQ) || (op_q == OP_REP);
        o_q_data = (op_q == OP_DEQ) ? '0 : key_q;
        state_d  = (SETTLE_CYCLES == 0) ? RESP : SETTLE;
      end
      SETTLE: if (settle_cnt == SETTLE_LAST) state_d = RESP;
      RESP:   if (cmd_if.o_rsp_valid && cmd_if.i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q           <= IDLE;
      op_q              <= OP_ENQ;
      key_q             <= '0;
      settle_cnt        <= '0;
      o_count           <= '0;
      cmd_if.o_rsp_valid <= 1'b0;
      cmd_if.o_rsp_data  <= '0;
      cmd_if.o_rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q              <= op_in;
        key_q             <= cmd_if.i_cmd_data;
        cmd_if.o_rsp_err  <= reject;
        cmd_if.o_rsp_data <= (!reject && (op_in == OP_DEQ || op_in == OP_REP)) ? i_q_data : '0;
      end
      settle_cnt <= ((state_q == SETTLE) && (settle_cnt != SETTLE_LAST)) ? settle_cnt + 1'b1 : '0;
      if (state_q == ISSUE) begin
        unique case (op_q)
          OP_ENQ:  if (o_count != COUNT_MAX) o_count <= o_count + 1'b1;
          OP_DEQ:  if (o_count != '0) o_count <= o_count - 1'b1;
          default: ;
        endcase
      end
      cmd_if.o_rsp_valid <= (state_q == RESP) && !(cmd_if.o_rsp_valid && cmd_if.i_rsp_ready);
    end
  end
endmodule
